alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 32-bit RV32I ALU datapath between up to four requesters, for example the execute stage and the branch/address unit. Each requester presents a full ALU operand bundle with a valid/ready handshake. The block registers the winning bundle, drives the ALU for exactly one cycle, captures `ALU_OUT`, and returns it to that requester with a response handshake. It sits between the requesters and the ALU top level; the ALU itself is unchanged.

---
 rtl/alu_arb_pkg.sv | 40 ++++
 rtl/rr_grant.sv | 29 ++
 rtl/alu_share_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types, field widths and round-robin helpers for the ALU sharing arbiter.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int OPC_W   = 7;
    localparam int F3_W    = 3;
    localparam int UIMM_W  = 20;
    localparam int IMM_W   = 12;
    localparam int SHAMT_W = 5;

    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    // Returns {any, index} of the first set request at or above ptr, wrapping at n.
    function automatic logic [IDX_W:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int                 n);
        logic [IDX_W:0] pick;
        int             idx;
        pick = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (req[IDX_W'(idx)]) pick = {1'b1, IDX_W'(idx)};
            end
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: one-hot grant, its index and an any-request flag.
module rr_grant
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [IDX_W:0]     w_pick;

    assign w_req_ext = MAX_REQ'(i_req);
    assign w_pick    = rr_pick(w_req_ext, i_ptr, N_REQ);
    assign o_any     = w_pick[IDX_W];
    assign o_idx     = w_pick[IDX_W-1:0];

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            o_grant[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one RV32I ALU between N_REQ requesters: arbitrate, drive the ALU for one
// cycle, then hold the captured result until the owning requester takes it.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         REQ_VALID,
    output logic [N_REQ-1:0]         REQ_READY,
    input  logic [OPC_W*N_REQ-1:0]   REQ_OPCODE,
    input  logic [F3_W*N_REQ-1:0]    REQ_FUNCT3,
    input  logic [N_REQ-1:0]         REQ_FUNCT1,
    input  logic [W*N_REQ-1:0]       REQ_RS1_DATA,
    input  logic [W*N_REQ-1:0]       REQ_RS2_DATA,
    input  logic [W*N_REQ-1:0]       REQ_PC,
    input  logic [UIMM_W*N_REQ-1:0]  REQ_U_IMM20,
    input  logic [IMM_W*N_REQ-1:0]   REQ_IMM12,
    input  logic [SHAMT_W*N_REQ-1:0] REQ_RS2,
    output logic [OPC_W-1:0]         ALU_OPCODE,
    output logic [F3_W-1:0]          ALU_FUNCT3,
    output logic                     ALU_FUNCT1,
    output logic [W-1:0]             ALU_RS1_DATA,
    output logic [W-1:0]             ALU_RS2_DATA,
    output logic [W-1:0]             ALU_PC,
    output logic [UIMM_W-1:0]        ALU_U_IMM20,
    output logic [IMM_W-1:0]         ALU_IMM12,
    output logic [SHAMT_W-1:0]       ALU_RS2,
    input  logic [W-1:0]             ALU_OUT,
    output logic [N_REQ-1:0]         RSP_VALID,
    input  logic [N_REQ-1:0]         RSP_READY,
    output logic [W-1:0]             RSP_DATA,
    output logic                     BUSY
);

    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [N_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_gany;
    logic               w_take;
    logic [N_REQ-1:0]   w_owner_oh;
    logic               w_rsp_ack;

    logic [OPC_W-1:0]   w_sel_opc,  r_alu_opc;
    logic [F3_W-1:0]    w_sel_f3,   r_alu_f3;
    logic               w_sel_f1,   r_alu_f1;
    logic [W-1:0]       w_sel_rs1,  r_alu_rs1;
    logic [W-1:0]       w_sel_rs2,  r_alu_rs2;
    logic [W-1:0]       w_sel_pc,   r_alu_pc;
    logic [UIMM_W-1:0]  w_sel_uimm, r_alu_uimm;
    logic [IMM_W-1:0]   w_sel_imm,  r_alu_imm;
    logic [SHAMT_W-1:0] w_sel_sh,   r_alu_sh;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [W-1:0]       r_rsp_data;
    logic               r_busy;

    rr_grant #(.N_REQ(N_REQ)) u_rr_grant (
        .i_req   (REQ_VALID),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_gany)
    );

    // Gated by RST_N so READY also drops the moment reset asserts.
    assign REQ_READY = (RST_N && r_state == IDLE) ? w_grant : '0;
    assign w_take    = (r_state == IDLE) && w_gany;

    always_comb begin
        w_owner_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_owner_oh[i] = (r_owner == IDX_W'(i));
        end
    end

    assign w_rsp_ack = |(RSP_READY & w_owner_oh);

    always_comb begin
        w_sel_opc  = '0;
        w_sel_f3   = '0;
        w_sel_f1   = 1'b0;
        w_sel_rs1  = '0;
        w_sel_rs2  = '0;
        w_sel_pc   = '0;
        w_sel_uimm = '0;
        w_sel_imm  = '0;
        w_sel_sh   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_opc  = REQ_OPCODE[i*OPC_W +: OPC_W];
                w_sel_f3   = REQ_FUNCT3[i*F3_W +: F3_W];
                w_sel_f1   = REQ_FUNCT1[i];
                w_sel_rs1  = REQ_RS1_DATA[i*W +: W];
                w_sel_rs2  = REQ_RS2_DATA[i*W +: W];
                w_sel_pc   = REQ_PC[i*W +: W];
                w_sel_uimm = REQ_U_IMM20[i*UIMM_W +: UIMM_W];
                w_sel_imm  = REQ_IMM12[i*IMM_W +: IMM_W];
                w_sel_sh   = REQ_RS2[i*SHAMT_W +: SHAMT_W];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_take) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (w_rsp_ack) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr       <= '0;
            r_owner     <= '0;
            r_alu_opc   <= '0;
            r_alu_f3    <= '0;
            r_alu_f1    <= 1'b0;
            r_alu_rs1   <= '0;
            r_alu_rs2   <= '0;
            r_alu_pc    <= '0;
            r_alu_uimm  <= '0;
            r_alu_imm   <= '0;
            r_alu_sh    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            if (w_take) begin
                r_owner    <= w_gidx;
                r_ptr      <= rr_next(w_gidx, N_REQ);
                r_alu_opc  <= w_sel_opc;
                r_alu_f3   <= w_sel_f3;
                r_alu_f1   <= w_sel_f1;
                r_alu_rs1  <= w_sel_rs1;
                r_alu_rs2  <= w_sel_rs2;
                r_alu_pc   <= w_sel_pc;
                r_alu_uimm <= w_sel_uimm;
                r_alu_imm  <= w_sel_imm;
                r_alu_sh   <= w_sel_sh;
            end
            if (r_state == EXEC) begin
                r_rsp_data  <= ALU_OUT;
                r_rsp_valid <= w_owner_oh;
            end
            if (r_state == RESP && w_rsp_ack) begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign ALU_OPCODE   = r_alu_opc;
    assign ALU_FUNCT3   = r_alu_f3;
    assign ALU_FUNCT1   = r_alu_f1;
    assign ALU_RS1_DATA = r_alu_rs1;
    assign ALU_RS2_DATA = r_alu_rs2;
    assign ALU_PC       = r_alu_pc;
    assign ALU_U_IMM20  = r_alu_uimm;
    assign ALU_IMM12    = r_alu_imm;
    assign ALU_RS2      = r_alu_sh;
    assign RSP_VALID    = r_rsp_valid;
    assign RSP_DATA     = r_rsp_data;
    assign BUSY         = r_busy;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 2-requester and a 4-requester instance,
// each fed by a small reference ALU model on its ALU_* outputs.
module tb_alu_share_arbiter;

    localparam int W = 32;

    typedef struct {
        int          idx;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f1;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [19:0] uimm;
        logic [11:0] imm;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-requester instance
    logic         d2_rst_n;
    logic [1:0]   d2_req_valid, d2_req_ready, d2_rsp_valid, d2_rsp_ready, d2_f1;
    logic [13:0]  d2_opc;
    logic [5:0]   d2_f3;
    logic [63:0]  d2_rs1, d2_rs2, d2_pc;
    logic [39:0]  d2_uimm;
    logic [23:0]  d2_imm;
    logic [9:0]   d2_sh;
    logic [6:0]   d2_a_opc;
    logic [2:0]   d2_a_f3;
    logic         d2_a_f1, d2_busy;
    logic [31:0]  d2_a_rs1, d2_a_rs2, d2_a_pc, d2_alu_out, d2_rsp_data;
    logic [19:0]  d2_a_uimm;
    logic [11:0]  d2_a_imm;
    logic [4:0]   d2_a_sh;

    // 4-requester instance
    logic         d4_rst_n;
    logic [3:0]   d4_req_valid, d4_req_ready, d4_rsp_valid, d4_rsp_ready, d4_f1;
    logic [27:0]  d4_opc;
    logic [11:0]  d4_f3;
    logic [127:0] d4_rs1, d4_rs2, d4_pc;
    logic [79:0]  d4_uimm;
    logic [47:0]  d4_imm;
    logic [19:0]  d4_sh;
    logic [6:0]   d4_a_opc;
    logic [2:0]   d4_a_f3;
    logic         d4_a_f1, d4_busy;
    logic [31:0]  d4_a_rs1, d4_a_rs2, d4_a_pc, d4_alu_out, d4_rsp_data;
    logic [19:0]  d4_a_uimm;
    logic [11:0]  d4_a_imm;
    logic [4:0]   d4_a_sh;

    alu_share_arbiter #(.N_REQ(2), .W(W)) u_dut2 (
        .CLK(clk), .RST_N(d2_rst_n),
        .REQ_VALID(d2_req_valid), .REQ_READY(d2_req_ready),
        .REQ_OPCODE(d2_opc), .REQ_FUNCT3(d2_f3), .REQ_FUNCT1(d2_f1),
        .REQ_RS1_DATA(d2_rs1), .REQ_RS2_DATA(d2_rs2), .REQ_PC(d2_pc),
        .REQ_U_IMM20(d2_uimm), .REQ_IMM12(d2_imm), .REQ_RS2(d2_sh),
        .ALU_OPCODE(d2_a_opc), .ALU_FUNCT3(d2_a_f3), .ALU_FUNCT1(d2_a_f1),
        .ALU_RS1_DATA(d2_a_rs1), .ALU_RS2_DATA(d2_a_rs2), .ALU_PC(d2_a_pc),
        .ALU_U_IMM20(d2_a_uimm), .ALU_IMM12(d2_a_imm), .ALU_RS2(d2_a_sh),
        .ALU_OUT(d2_alu_out),
        .RSP_VALID(d2_rsp_valid), .RSP_READY(d2_rsp_ready), .RSP_DATA(d2_rsp_data),
        .BUSY(d2_busy)
    );

    alu_share_arbiter #(.N_REQ(4), .W(W)) u_dut4 (
        .CLK(clk), .RST_N(d4_rst_n),
        .REQ_VALID(d4_req_valid), .REQ_READY(d4_req_ready),
        .REQ_OPCODE(d4_opc), .REQ_FUNCT3(d4_f3), .REQ_FUNCT1(d4_f1),
        .REQ_RS1_DATA(d4_rs1), .REQ_RS2_DATA(d4_rs2), .REQ_PC(d4_pc),
        .REQ_U_IMM20(d4_uimm), .REQ_IMM12(d4_imm), .REQ_RS2(d4_sh),
        .ALU_OPCODE(d4_a_opc), .ALU_FUNCT3(d4_a_f3), .ALU_FUNCT1(d4_a_f1),
        .ALU_RS1_DATA(d4_a_rs1), .ALU_RS2_DATA(d4_a_rs2), .ALU_PC(d4_a_pc),
        .ALU_U_IMM20(d4_a_uimm), .ALU_IMM12(d4_a_imm), .ALU_RS2(d4_a_sh),
        .ALU_OUT(d4_alu_out),
        .RSP_VALID(d4_rsp_valid), .RSP_READY(d4_rsp_ready), .RSP_DATA(d4_rsp_data),
        .BUSY(d4_busy)
    );

    function automatic logic [31:0] alu_model(input logic [6:0] opc, input logic [2:0] f3,
                                              input logic f1, input logic [31:0] rs1,
                                              input logic [31:0] rs2, input logic [31:0] pc,
                                              input logic [19:0] uimm, input logic [11:0] imm,
                                              input logic [4:0] sh);
        logic [31:0] simm;
        simm = {{20{imm[11]}}, imm};
        case (opc)
            7'h13:   case (f3)
                         3'd0:    return rs1 + simm;
                         3'd1:    return rs1 << sh;
                         3'd4:    return rs1 ^ simm;
                         default: return 32'd0;
                     endcase
            7'h33:   case (f3)
                         3'd0:    return f1 ? rs1 - rs2 : rs1 + rs2;
                         3'd4:    return rs1 ^ rs2;
                         default: return 32'd0;
                     endcase
            7'h37:   return {uimm, 12'd0};
            7'h17:   return pc + {uimm, 12'd0};
            default: return 32'd0;
        endcase
    endfunction

    assign d2_alu_out = alu_model(d2_a_opc, d2_a_f3, d2_a_f1, d2_a_rs1, d2_a_rs2, d2_a_pc,
                                  d2_a_uimm, d2_a_imm, d2_a_sh);
    assign d4_alu_out = alu_model(d4_a_opc, d4_a_f3, d4_a_f1, d4_a_rs1, d4_a_rs2, d4_a_pc,
                                  d4_a_uimm, d4_a_imm, d4_a_sh);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic junk2();
        d2_opc = '1; d2_f3 = '1; d2_f1 = '1; d2_rs1 = '1; d2_rs2 = '1;
        d2_pc = '1; d2_uimm = '1; d2_imm = '1; d2_sh = '1;
    endtask

    task automatic junk4();
        d4_opc = '1; d4_f3 = '1; d4_f1 = '1; d4_rs1 = '1; d4_rs2 = '1;
        d4_pc = '1; d4_uimm = '1; d4_imm = '1; d4_sh = '1;
    endtask

    task automatic slice2(input vec_t v);
        d2_opc[v.idx*7 +: 7]   = v.opc;
        d2_f3[v.idx*3 +: 3]    = v.f3;
        d2_f1[v.idx]           = v.f1;
        d2_rs1[v.idx*32 +: 32] = v.rs1;
        d2_rs2[v.idx*32 +: 32] = v.rs2;
        d2_pc[v.idx*32 +: 32]  = v.pc;
        d2_uimm[v.idx*20 +: 20] = v.uimm;
        d2_imm[v.idx*12 +: 12] = v.imm;
        d2_sh[v.idx*5 +: 5]    = v.sh;
    endtask

    task automatic slice4(input vec_t v);
        d4_opc[v.idx*7 +: 7]   = v.opc;
        d4_f3[v.idx*3 +: 3]    = v.f3;
        d4_f1[v.idx]           = v.f1;
        d4_rs1[v.idx*32 +: 32] = v.rs1;
        d4_rs2[v.idx*32 +: 32] = v.rs2;
        d4_pc[v.idx*32 +: 32]  = v.pc;
        d4_uimm[v.idx*20 +: 20] = v.uimm;
        d4_imm[v.idx*12 +: 12] = v.imm;
        d4_sh[v.idx*5 +: 5]    = v.sh;
    endtask

    // One full transaction on the 2-requester DUT; starts and ends just after a rising edge.
    task automatic run_vec2(input vec_t v);
        logic [1:0] oh;
        oh = 2'(1 << v.idx);
        junk2();
        slice2(v);
        d2_req_valid = oh;
        @(negedge clk);
        chk("idle_ready", 32'(d2_req_ready), 32'(oh));
        chk("idle_busy", 32'(d2_busy), 0);
        cyc();
        d2_req_valid = '0;
        @(negedge clk);
        chk("exec_busy", 32'(d2_busy), 1);
        chk("exec_rsp_valid", 32'(d2_rsp_valid), 0);
        chk("exec_ready", 32'(d2_req_ready), 0);
        chk("alu_opcode", 32'(d2_a_opc), 32'(v.opc));
        chk("alu_funct3", 32'(d2_a_f3), 32'(v.f3));
        chk("alu_funct1", 32'(d2_a_f1), 32'(v.f1));
        chk("alu_rs1", d2_a_rs1, v.rs1);
        chk("alu_rs2", d2_a_rs2, v.rs2);
        chk("alu_pc", d2_a_pc, v.pc);
        chk("alu_uimm", 32'(d2_a_uimm), 32'(v.uimm));
        chk("alu_imm", 32'(d2_a_imm), 32'(v.imm));
        chk("alu_shamt", 32'(d2_a_sh), 32'(v.sh));
        cyc();
        @(negedge clk);
        chk("resp_valid", 32'(d2_rsp_valid), 32'(oh));
        chk("resp_data", d2_rsp_data, v.exp);
        chk("resp_busy", 32'(d2_busy), 1);
        cyc();
        @(negedge clk);
        chk("after_busy", 32'(d2_busy), 0);
        chk("after_rsp_valid", 32'(d2_rsp_valid), 0);
        cyc();
    endtask

    task automatic chk_reset2(input string tag);
        chk({tag, "_ready"}, 32'(d2_req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(d2_rsp_valid), 0);
        chk({tag, "_rsp_data"}, d2_rsp_data, 0);
        chk({tag, "_busy"}, 32'(d2_busy), 0);
        chk({tag, "_alu_opc"}, 32'(d2_a_opc), 0);
        chk({tag, "_alu_f3"}, 32'(d2_a_f3), 0);
        chk({tag, "_alu_f1"}, 32'(d2_a_f1), 0);
        chk({tag, "_alu_rs1"}, d2_a_rs1, 0);
        chk({tag, "_alu_rs2"}, d2_a_rs2, 0);
        chk({tag, "_alu_pc"}, d2_a_pc, 0);
        chk({tag, "_alu_uimm"}, 32'(d2_a_uimm), 0);
        chk({tag, "_alu_imm"}, 32'(d2_a_imm), 0);
        chk({tag, "_alu_sh"}, 32'(d2_a_sh), 0);
    endtask

    vec_t vecs[8];
    vec_t va, vb;
    int   order[4];
    int   ng;

    initial begin
        //            idx opc    f3 f1 rs1            rs2       pc        uimm      imm      sh  exp
        vecs[0] = '{0, 7'h13, 0, 0, 32'd5,         32'h0A0A, 32'h100,  20'hABC,  12'd7,   3, 32'd12};
        vecs[1] = '{1, 7'h33, 0, 0, 32'h10,        32'h22,   32'h104,  20'h1,    12'h5,   2, 32'h32};
        vecs[2] = '{0, 7'h33, 0, 1, 32'h100,       32'h1,    32'h108,  20'h2,    12'h0,   1, 32'hFF};
        vecs[3] = '{1, 7'h37, 0, 0, 32'hDEAD,      32'hBEEF, 32'h10C,  20'h12345, 12'h321, 0, 32'h12345000};
        vecs[4] = '{0, 7'h17, 0, 0, 32'h5,         32'h6,    32'h1000, 20'h1,    12'h1,   0, 32'h2000};
        vecs[5] = '{1, 7'h13, 4, 0, 32'hFF00FF00,  32'h0,    32'h110,  20'h0,    12'hFFF, 0, 32'h00FF00FF};
        vecs[6] = '{0, 7'h13, 1, 0, 32'd3,         32'h0,    32'h114,  20'h0,    12'h4,   4, 32'h30};
        vecs[7] = '{1, 7'h13, 0, 0, 32'h0,         32'h0,    32'h118,  20'h0,    12'h800, 0, 32'hFFFFF800};

        d2_rst_n = 1'b0; d4_rst_n = 1'b0;
        d2_req_valid = '0; d4_req_valid = '0;
        d2_rsp_ready = '1; d4_rsp_ready = '1;
        junk2(); junk4();
        #12;
        chk_reset2("reset");
        chk("reset4_busy", 32'(d4_busy), 0);
        chk("reset4_rsp_valid", 32'(d4_rsp_valid), 0);
        cyc();
        d2_rst_n = 1'b1; d4_rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) run_vec2(vecs[i]);

        // 4-requester: move PTR to 2 by serving requester 1, then race 1 against 3
        junk4();
        va = '{1, 7'h13, 0, 0, 32'd1, 32'd0, 32'h200, 20'd0, 12'd1, 0, 32'd2};
        slice4(va);
        d4_req_valid = 4'b0010;
        @(negedge clk);
        chk("f4_first_ready", 32'(d4_req_ready), 32'b0010);
        cyc();
        d4_req_valid = '0;
        cyc();
        @(negedge clk);
        chk("f4_first_rsp", 32'(d4_rsp_valid), 32'b0010);
        chk("f4_first_data", d4_rsp_data, 2);
        cyc();
        va = '{3, 7'h13, 0, 0, 32'd10, 32'd0, 32'h300, 20'd0, 12'd3, 0, 32'd13};
        vb = '{1, 7'h13, 0, 0, 32'd20, 32'd0, 32'h304, 20'd0, 12'd4, 0, 32'd24};
        slice4(va);
        slice4(vb);
        d4_req_valid = 4'b1010;
        @(negedge clk);
        chk("f4_ptr2_ready", 32'(d4_req_ready), 32'b1000);
        cyc();
        d4_req_valid = 4'b0010;
        @(negedge clk);
        chk("f4_exec_rs1", d4_a_rs1, 32'd10);
        chk("f4_exec_ready", 32'(d4_req_ready), 0);
        cyc();
        @(negedge clk);
        chk("f4_rsp3", 32'(d4_rsp_valid), 32'b1000);
        chk("f4_data3", d4_rsp_data, 32'd13);
        cyc();
        @(negedge clk);
        chk("f4_second_ready", 32'(d4_req_ready), 32'b0010);
        cyc();
        d4_req_valid = '0;
        cyc();
        @(negedge clk);
        chk("f4_rsp1", 32'(d4_rsp_valid), 32'b0010);
        chk("f4_data1", d4_rsp_data, 32'd24);
        cyc();

        // Contention from reset on the 2-requester DUT
        d2_rst_n = 1'b0;
        junk2();
        va = '{0, 7'h13, 0, 0, 32'd1, 32'd0, 32'h400, 20'd0, 12'd1, 0, 32'd2};
        vb = '{1, 7'h13, 0, 0, 32'd2, 32'd0, 32'h404, 20'd0, 12'd2, 0, 32'd4};
        slice2(va);
        slice2(vb);
        d2_req_valid = 2'b11;
        @(negedge clk);
        chk("cont_reset_ready", 32'(d2_req_ready), 0);
        cyc();
        d2_rst_n = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            chk("cont_ready_onehot", 32'(d2_req_ready == 2'b11), 0);
            if (d2_req_ready != 2'b00) begin
                order[ng] = d2_req_ready[1] ? 1 : 0;
                ng++;
            end
        end
        chk("cont_grant_count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) chk("cont_grant_order", 32'(order[k]), 32'(k % 2));
        end
        cyc();
        d2_req_valid = '0;
        repeat (4) cyc();

        // Response backpressure on requester 1 while requester 0 waits
        junk2();
        va = '{1, 7'h33, 4, 0, 32'hF0F0, 32'h0FF0, 32'h500, 20'd0, 12'd0, 0, 32'hFF00};
        vb = '{0, 7'h13, 0, 0, 32'd100, 32'd0, 32'h504, 20'd0, 12'd5, 0, 32'd105};
        slice2(va);
        d2_req_valid = 2'b10;
        d2_rsp_ready = 2'b01;
        @(negedge clk);
        chk("bp_ready1", 32'(d2_req_ready), 32'b10);
        cyc();
        slice2(vb);
        d2_req_valid = 2'b01;
        cyc();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(d2_rsp_valid), 32'b10);
            chk("bp_rsp_data", d2_rsp_data, 32'hFF00);
            chk("bp_no_ready", 32'(d2_req_ready), 0);
            chk("bp_busy", 32'(d2_busy), 1);
            cyc();
        end
        d2_rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_still_valid", 32'(d2_rsp_valid), 32'b10);
        cyc();
        @(negedge clk);
        chk("bp_idle_busy", 32'(d2_busy), 0);
        chk("bp_idle_rsp", 32'(d2_rsp_valid), 0);
        chk("bp_next_grant", 32'(d2_req_ready), 32'b01);
        cyc();
        d2_req_valid = '0;
        cyc();
        @(negedge clk);
        chk("bp_req0_rsp", 32'(d2_rsp_valid), 32'b01);
        chk("bp_req0_data", d2_rsp_data, 32'd105);
        cyc();
        cyc();

        // Reset asserted during EXEC
        junk2();
        va = '{0, 7'h33, 0, 1, 32'd7, 32'd9, 32'h600, 20'h55, 12'h66, 7, 32'hFFFFFFFE};
        slice2(va);
        d2_req_valid = 2'b01;
        @(negedge clk);
        cyc();
        d2_req_valid = '0;
        @(negedge clk);
        chk("rx_exec_busy", 32'(d2_busy), 1);
        #2;
        d2_rst_n = 1'b0;
        #1;
        chk_reset2("rx");
        cyc();
        d2_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rx_no_rsp", 32'(d2_rsp_valid), 0);
            chk("rx_no_busy", 32'(d2_busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
